div_iter: RTL and testbench
===========================

// Module: div_iter
// PURPOSE
//  Iterative 32/32 radix-2 restoring divider for the EX-stage HI/LO unit. It is the
//  inverse-operation companion of the multiplier and uses the same start/done handshake.
//  It produces {remainder, quotient} in one 64-bit result. HI takes the remainder and
//  LO takes the quotient, for DIV/DIVU.
// PARAMETERS
//  WIDTH    32  operand width; result is 2*WIDTH (only 32 is verified)
// PORTS
//  clock          in   1   clock; all state changes on the rising edge
//  reset          in   1   reset, synchronous, active-high
//  start          in   1   launch request; sampled only in IDLE
//  flag_unsigned  in   1   1: DIVU, 0: DIV (two's complement); sampled with start
//  operand1       in   32  dividend; latched on accepted start
//  operand2       in   32  divisor; latched on accepted start
//  cancel         in   1   abort the operation in flight (EX flush or exception)
//  result         out  64  {remainder[63:32], quotient[31:0]}; held between operations
//  done           out  1   one-cycle pulse: result was updated on this edge
//  busy           out  1   high in every state except IDLE
// BEHAVIOUR
//  - Reset: result=0, done=0, busy=0, state=IDLE. Reset mid-operation drops the operation.
//  - States:
//    - IDLE -> RUN on start. Latches |op1|, |op2| and the signs (magnitudes are raw when
//      unsigned). Clears the partial remainder. Sets count=0.
//    - RUN runs 32 iterations, one per edge:
//      - Shift {rem, quo} left by 1.
//      - Compute trial = rem - divisor (33-bit).
//      - If trial is non-negative: rem = trial and quo[0] = 1.
//      - Exits to FIX after count 31.
//    - FIX (1 edge) applies the sign correction:
//      - Quotient is negated if sign1^sign2 (signed mode only).
//      - Remainder is negated if sign1 (remainder takes the dividend's sign).
//      - Writes result, pulses done, then goes to IDLE.
//  - Latency: start accepted at edge k gives result and done=1 after edge k+33. done
//    falls after edge k+34. Back-to-back: a new start in the cycle after done is accepted.
//  - done is 0 in every cycle except the completion cycle.
//  - done is never asserted for a cancelled or reset operation.
//  - start while busy is ignored; no queuing.
//  - start and cancel together in IDLE: start wins.
//  - cancel in RUN, FIX or ZERO: goes to IDLE on the next edge. result is unchanged and
//    done stays 0. cancel has priority over completion on the same edge.
//  - Operand inputs may change after the accepted start with no effect.
//  - Arithmetic:
//    - The magnitude of 0x8000_0000 is 0x8000_0000 as a 32-bit unsigned value.
//    - -2^31 / -1 gives quotient 0x8000_0000, remainder 0. No trap; overflow is
//      silently wrapped.
// CONFIGURATION
//  DIV_ZERO_SHORTCUT_EN
//    - Defined: divisor==0 at start sends IDLE -> ZERO.
//      - ZERO writes result={operand1, 32'hFFFF_FFFF}, pulses done after edge k+1,
//        then goes to IDLE.
//      - This applies in both signed and unsigned mode.
//    - Undefined: the ZERO state does not exist. A zero divisor takes the normal 33-edge
//      path.
//      - Unsigned result is {operand1, 32'hFFFF_FFFF}.
//      - Signed result is whatever the algorithm produces; it is architecturally
//        UNPREDICTABLE and not checked.
// TESTING
//  - Unsigned: 100 / 7, flag_unsigned=1 -> done after edge k+33;
//    result={32'd2, 32'd14}; busy high for 33 cycles.
//  - Signed: -7 / 2 -> quotient 0xFFFF_FFFD (-3), remainder 0xFFFF_FFFF (-1).
//    7 / -2 -> quotient -3, remainder 1.
//  - Overflow: 0x8000_0000 / 0xFFFF_FFFF signed -> result={32'h0, 32'h8000_0000}.
//    Same operands unsigned -> {32'h8000_0000, 32'h0}.
//  - Cancel: start 1000/3; cancel at k+10 -> busy low after k+11; no done; result keeps
//    its previous value. A restart then completes normally with {1, 333}.
//  - Divide by zero with macro: 5 / 0 -> done after k+1, result={32'd5, 32'hFFFF_FFFF}.
//    Without macro, unsigned -> the same result after k+33.
//  - Handshake: start held high through an operation -> only one launch until done.
//    A second launch begins the cycle after done; reset at k+5 -> all outputs 0 and no
//    done.

Source files
------------

// File: rtl/div_iter_if.sv
// Start/done handshake bundle for the iterative divider.
//   master: start, flag_unsigned, operand1, operand2, cancel -> ; <- result, done, busy
//   slave : the divider side of the same signals
interface div_iter_if #(
  parameter int unsigned WIDTH = 32
);
  logic               start;
  logic               flag_unsigned;
  logic [WIDTH-1:0]   operand1;
  logic [WIDTH-1:0]   operand2;
  logic               cancel;
  logic [2*WIDTH-1:0] result;
  logic               done;
  logic               busy;

  modport master (
    output start, flag_unsigned, operand1, operand2, cancel,
    input  result, done, busy
  );

  modport slave (
    input  start, flag_unsigned, operand1, operand2, cancel,
    output result, done, busy
  );
endinterface

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider for the HI/LO unit (DIV/DIVU).
// Produces {remainder, quotient}; HI takes the remainder, LO the quotient.
// Ports:
//   clock            rising-edge clock
//   reset            synchronous, active-high
//   bus (slave)      start, flag_unsigned, operand1 (dividend), operand2 (divisor),
//                    cancel in; result {rem, quo}, done (1-cycle pulse), busy out
// Optional feature: define DIV_ZERO_SHORTCUT_EN to finish a zero-divisor operation in
// one cycle with result {operand1, all ones} via a dedicated ZERO state.
module div_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic       clock,
  input  logic       reset,
  div_iter_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam int unsigned RES_W = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
`ifdef DIV_ZERO_SHORTCUT_EN
    , S_ZERO = 2'd3
`endif
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic               neg_rem_q, neg_rem_d;
  logic               neg_quo_q, neg_quo_d;
  logic [RES_W-1:0]   result_q, result_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;

  // Operand signs and magnitudes; signs are forced to 0 in unsigned mode.
  logic               sign1, sign2;
  logic [WIDTH-1:0]   op1_mag, op2_mag;

  assign sign1   = ~bus.flag_unsigned & bus.operand1[WIDTH-1];
  assign sign2   = ~bus.flag_unsigned & bus.operand2[WIDTH-1];
  assign op1_mag = sign1 ? WIDTH'(~bus.operand1 + 1'b1) : bus.operand1;
  assign op2_mag = sign2 ? WIDTH'(~bus.operand2 + 1'b1) : bus.operand2;

  // One restoring step: shift {rem, quo} left, trial-subtract the divisor.
  // rem_sh < 2*divisor, so a non-negative trial always has its top bit clear and a
  // negative one always has it set: trial[WIDTH] is the sign.
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     trial;
  logic               trial_neg;
  logic [WIDTH-1:0]   rem_step;
  logic [WIDTH-1:0]   quo_step;

  assign rem_sh    = {rem_q, quo_q[WIDTH-1]};
  assign trial     = rem_sh - {1'b0, dvs_q};
  assign trial_neg = trial[WIDTH];
  assign rem_step  = trial_neg ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quo_step  = {quo_q[WIDTH-2:0], ~trial_neg};

  // Sign correction applied in FIX: remainder follows the dividend's sign.
  logic [WIDTH-1:0]   rem_fix, quo_fix;

  assign rem_fix = neg_rem_q ? WIDTH'(~rem_q + 1'b1) : rem_q;
  assign quo_fix = neg_quo_q ? WIDTH'(~quo_q + 1'b1) : quo_q;

  // State and datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_rem_q <= 1'b0;
      neg_quo_q <= 1'b0;
      result_q  <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      neg_rem_q <= neg_rem_d;
      neg_quo_q <= neg_quo_d;
      result_q  <= result_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  // Next-state logic; cancel beats completion, start beats cancel in IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
`ifdef DIV_ZERO_SHORTCUT_EN
          if (bus.operand2 == '0) state_d = S_ZERO;
          else                    state_d = S_RUN;
`else
          state_d = S_RUN;
`endif
        end
      end
      S_RUN: begin
        if (bus.cancel)                             state_d = S_IDLE;
        else if (count_q == CNT_W'(WIDTH - 1))      state_d = S_FIX;
      end
      S_FIX:  state_d = S_IDLE;
`ifdef DIV_ZERO_SHORTCUT_EN
      S_ZERO: state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values.
  always_comb begin
    count_d   = count_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    neg_rem_d = neg_rem_q;
    neg_quo_d = neg_quo_q;
    result_d  = result_q;
    done_d    = 1'b0;
    busy_d    = (state_d != S_IDLE);
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          count_d   = '0;
          rem_d     = '0;
          quo_d     = op1_mag;
          dvs_d     = op2_mag;
          neg_rem_d = sign1;
          neg_quo_d = sign1 ^ sign2;
`ifdef DIV_ZERO_SHORTCUT_EN
          // ZERO reports the raw dividend as the remainder.
          if (bus.operand2 == '0) quo_d = bus.operand1;
`endif
        end
      end
      S_RUN: begin
        if (!bus.cancel) begin
          rem_d   = rem_step;
          quo_d   = quo_step;
          count_d = count_q + 1'b1;
        end
      end
      S_FIX: begin
        if (!bus.cancel) begin
          result_d = {rem_fix, quo_fix};
          done_d   = 1'b1;
        end
      end
`ifdef DIV_ZERO_SHORTCUT_EN
      S_ZERO: begin
        if (!bus.cancel) begin
          result_d = {quo_q, {WIDTH{1'b1}}};
          done_d   = 1'b1;
        end
      end
`endif
      default: ;
    endcase
  end

  assign bus.result = result_q;
  assign bus.done   = done_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_div_iter.sv
// Directed self-checking bench for div_iter.
module tb_div_iter;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_errors;

  div_iter_if #(.WIDTH(32)) bus ();

  div_iter #(.WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Launch one operation, scramble operands afterwards, and check latency/busy/result.
  task automatic run_op(input string tag, input logic us, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat, input logic [63:0] exp_res);
    int cyc;
    int busy_cnt;
    bus.flag_unsigned = us;
    bus.operand1      = a;
    bus.operand2      = b;
    bus.start         = 1'b1;
    tick();
    bus.start         = 1'b0;
    bus.operand1      = 32'hDEAD_BEEF;
    bus.operand2      = 32'h0000_0003;
    bus.flag_unsigned = ~us;
    cyc      = 0;
    busy_cnt = 0;
    while (bus.done !== 1'b1 && cyc < 200) begin
      if (bus.busy === 1'b1) busy_cnt++;
      tick();
      cyc++;
    end
    check({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
    check({tag, "_res"}, bus.result, exp_res);
    check({tag, "_busycyc"}, 64'(busy_cnt), 64'(exp_lat));
    check({tag, "_busy_at_done"}, 64'(bus.busy), 64'd0);
    tick();
    check({tag, "_done_fall"}, 64'(bus.done), 64'd0);
    check({tag, "_hold"}, bus.result, exp_res);
  endtask

  initial begin
    int cyc;
    int dcnt;
    n_checks          = 0;
    n_errors          = 0;
    reset             = 1'b1;
    bus.start         = 1'b0;
    bus.flag_unsigned = 1'b0;
    bus.operand1      = '0;
    bus.operand2      = '0;
    bus.cancel        = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    check("rst_result", bus.result, 64'd0);
    check("rst_done",   64'(bus.done), 64'd0);
    check("rst_busy",   64'(bus.busy), 64'd0);

    // Unsigned and signed arithmetic.
    run_op("u100_7",  1'b1, 32'd100, 32'd7, 33, {32'd2, 32'd14});
    run_op("s-7_2",   1'b0, 32'hFFFF_FFF9, 32'd2, 33, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_op("s7_-2",   1'b0, 32'd7, 32'hFFFF_FFFE, 33, {32'd1, 32'hFFFF_FFFD});
    run_op("s-7_-2",  1'b0, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 33, {32'hFFFF_FFFF, 32'd3});
    run_op("s_ovf",   1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 33, {32'h0, 32'h8000_0000});
    run_op("u_ovfop", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, {32'h8000_0000, 32'h0});
    run_op("u_max_1", 1'b1, 32'hFFFF_FFFF, 32'd1, 33, {32'h0, 32'hFFFF_FFFF});
    run_op("u_small", 1'b1, 32'd3, 32'd10, 33, {32'd3, 32'd0});

    // Divide by zero.
`ifdef DIV_ZERO_SHORTCUT_EN
    run_op("u_div0", 1'b1, 32'd5, 32'd0, 1, {32'd5, 32'hFFFF_FFFF});
    run_op("s_div0", 1'b0, 32'hFFFF_FFF9, 32'd0, 1, {32'hFFFF_FFF9, 32'hFFFF_FFFF});
`else
    run_op("u_div0", 1'b1, 32'd5, 32'd0, 33, {32'd5, 32'hFFFF_FFFF});
`endif

    // Cancel mid-run: result keeps the previous value, no done.
    run_op("pre_cancel", 1'b1, 32'd50, 32'd5, 33, {32'd0, 32'd10});
    bus.flag_unsigned = 1'b1;
    bus.operand1      = 32'd1000;
    bus.operand2      = 32'd3;
    bus.start         = 1'b1;
    tick();
    bus.start = 1'b0;
    dcnt = 0;
    repeat (10) begin
      tick();
      if (bus.done === 1'b1) dcnt++;
    end
    bus.cancel = 1'b1;
    tick();
    bus.cancel = 1'b0;
    check("cancel_busy",   64'(bus.busy), 64'd0);
    check("cancel_result", bus.result, {32'd0, 32'd10});
    repeat (40) begin
      if (bus.done === 1'b1) dcnt++;
      tick();
    end
    check("cancel_nodone", 64'(dcnt), 64'd0);
    check("cancel_keep",   bus.result, {32'd0, 32'd10});
    run_op("restart", 1'b1, 32'd1000, 32'd3, 33, {32'd1, 32'd333});

    // Start held high: single launch, then the next launch right after done.
    bus.flag_unsigned = 1'b1;
    bus.operand1      = 32'd100;
    bus.operand2      = 32'd7;
    bus.start         = 1'b1;
    tick();
    bus.operand1 = 32'd1000;
    bus.operand2 = 32'd3;
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < 200) begin
      tick();
      cyc++;
    end
    check("hold_lat1", 64'(cyc), 64'd33);
    check("hold_res1", bus.result, {32'd2, 32'd14});
    cyc = 0;
    tick();
    cyc++;
    check("hold_relaunch_busy", 64'(bus.busy), 64'd1);
    check("hold_relaunch_done", 64'(bus.done), 64'd0);
    while (bus.done !== 1'b1 && cyc < 200) begin
      tick();
      cyc++;
    end
    bus.start = 1'b0;
    check("hold_lat2", 64'(cyc), 64'd34);
    check("hold_res2", bus.result, {32'd1, 32'd333});
    tick();

    // Reset mid-operation.
    bus.operand1 = 32'd77;
    bus.operand2 = 32'd4;
    bus.start    = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_result", bus.result, 64'd0);
    check("midrst_done",   64'(bus.done), 64'd0);
    check("midrst_busy",   64'(bus.busy), 64'd0);
    dcnt = 0;
    repeat (40) begin
      if (bus.done === 1'b1) dcnt++;
      tick();
    end
    check("midrst_nodone", 64'(dcnt), 64'd0);
    run_op("post_rst", 1'b0, 32'hFFFF_FF9C, 32'd7, 33, {32'hFFFF_FFFE, 32'hFFFF_FFF2});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
